// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Data-memory req/ack bus between the load/store unit and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  dmem_ack;

  // Load/store unit side: drives the request, receives the response.
  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ack
  );

  // Memory side: receives the request, returns data and completion.
  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Load/store unit. Issues one req/ack data-memory transaction
//               per load/store, stalls the core while it is outstanding,
//               aligns/extends load data and builds store lanes/byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  mem_read,
  input  wire logic                  mem_write,
  input  wire logic [2:0]            funct3,
  input  wire logic [DATA_WIDTH-1:0] addr,
  input  wire logic [DATA_WIDTH-1:0] store_data,
  output logic                       stall,
  output logic [DATA_WIDTH-1:0]      load_data,
  output logic                       load_valid,
  output logic                       misaligned,
  output logic                       access_err,
  lsu_mem_stage_if.master            dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_BE_ALL = 4'b1111;

  state_t r_state;
  state_t w_next_state;

  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [DATA_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic [3:0]            r_dmem_be;
  logic [1:0]            r_offset;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_load_valid;

  logic                  w_access;
  logic                  w_is_store;
  logic                  w_f3_legal;
  logic                  w_aligned;
  logic [3:0]            w_store_be;
  logic [DATA_WIDTH-1:0] w_store_wdata;
  logic                  w_start;
  logic                  w_finish;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [DATA_WIDTH-1:0] w_load_ext;

  // A simultaneous read+write is treated as a store.
  assign w_access   = mem_read | mem_write;
  assign w_is_store = mem_write;

  // Decode legality of funct3 and alignment of the address for this access size.
  always_comb begin
    w_f3_legal = 1'b0;
    w_aligned  = 1'b1;
    if (w_is_store) begin
      w_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_store_be    = c_BE_ALL;
    w_store_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_store_be    = 4'b0001 << addr[1:0];
        w_store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_store_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_store_be    = c_BE_ALL;
        w_store_wdata = store_data;
      end
    endcase
  end

  // Select and extend the addressed byte/half of the returned read word.
  always_comb begin
    w_rbyte    = 8'h00;
    w_rhalf    = r_offset[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    w_load_ext = dmem.dmem_rdata;
    case (r_offset)
      2'd0:    w_rbyte = dmem.dmem_rdata[7:0];
      2'd1:    w_rbyte = dmem.dmem_rdata[15:8];
      2'd2:    w_rbyte = dmem.dmem_rdata[23:16];
      default: w_rbyte = dmem.dmem_rdata[31:24];
    endcase
    case (r_funct3)
      3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_rbyte[7]}}, w_rbyte};
      3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_rhalf[15]}}, w_rhalf};
      3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_rbyte};
      3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_rhalf};
      default: w_load_ext = dmem.dmem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, stall and rejection flags; requests in DONE are ignored.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    misaligned   = 1'b0;
    access_err   = 1'b0;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (!w_f3_legal) begin
            access_err = 1'b1;
          end else if (!w_aligned) begin
            misaligned = 1'b1;
          end else begin
            stall        = 1'b1;
            w_start      = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (dmem.dmem_ack) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Bus request registers and load result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= 4'b0000;
      r_offset     <= 2'b00;
      r_funct3     <= 3'b000;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      if (w_start) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= w_is_store;
        r_dmem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
        r_dmem_be    <= w_is_store ? w_store_be : c_BE_ALL;
        r_dmem_wdata <= w_is_store ? w_store_wdata : '0;
        r_offset     <= addr[1:0];
        r_funct3     <= funct3;
      end
      if (w_finish) begin
        r_dmem_req <= 1'b0;
        if (!r_dmem_we) begin
          r_load_data  <= w_load_ext;
          r_load_valid <= 1'b1;
        end
      end
    end
  end

  assign dmem.dmem_req   = r_dmem_req;
  assign dmem.dmem_we    = r_dmem_we;
  assign dmem.dmem_addr  = r_dmem_addr;
  assign dmem.dmem_wdata = r_dmem_wdata;
  assign dmem.dmem_be    = r_dmem_be;
  assign load_data       = r_load_data;
  assign load_valid      = r_load_valid;

endmodule
`default_nettype wire
